nvme_cdc_evt_tx: RTL and testbench

//  Source-domain end of a toggle req/ack event-count crossing. Accumulates event

---
 rtl/nvme_cdc_evt_tx.sv | 132 +++++++++++++
 tb/tb_nvme_cdc_evt_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nvme_cdc_evt_tx.sv
// Source end of a toggle req/ack crossing that ships saturating event counts.
// The data word is held from launch until the synchronized ack returns.
module nvme_cdc_evt_tx #(
  parameter int STAGES = 3,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_evt,
  input  logic          i_ack,
  input  logic          i_overflow_clr,
  output logic          o_req,
  output logic [CW-1:0] o_data,
  output logic          o_busy,
  output logic          o_overflow,
  output logic          o_proto_err
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t state_q, state_d;

  (* ASYNC_REG = "TRUE" *)
  logic [STAGES-1:0] sync_q;

  logic          ack_s;
  logic [CW-1:0] acc_q;
  logic          req_q;
  logic [CW-1:0] data_q;
  logic          busy_q;
  logic          ovf_q;
  logic          perr_q;
  logic          acc_nz;
  logic          acc_sat;
  logic          launch;
  logic          done;

  assign ack_s   = sync_q[STAGES-1];
  assign acc_nz  = (acc_q != '0);
  assign acc_sat = (acc_q == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_ack};
    end
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc_nz) begin
          launch  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ack_s == req_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A same-edge event seeds the fresh count so it is never dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (launch) begin
      acc_q <= CW'(i_evt);
    end else if (i_evt && !acc_sat) begin
      acc_q <= acc_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q  <= 1'b0;
      data_q <= '0;
      busy_q <= 1'b0;
    end else if (launch) begin
      req_q  <= ~req_q;
      data_q <= acc_q;
      busy_q <= 1'b1;
    end else if (done) begin
      busy_q <= 1'b0;
    end
  end

  // Set has priority over clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (i_evt && acc_sat && !launch) begin
      ovf_q <= 1'b1;
    end else if (i_overflow_clr) begin
      ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
    end else if (state_q == IDLE && ack_s != req_q) begin
      perr_q <= 1'b1;
    end
  end

  assign o_req       = req_q;
  assign o_data      = data_q;
  assign o_busy      = busy_q;
  assign o_overflow  = ovf_q;
  assign o_proto_err = perr_q;

endmodule

// File: tb/tb_nvme_cdc_evt_tx.sv
// Directed bench for nvme_cdc_evt_tx with a 5-clock destination ack model.
module tb_nvme_cdc_evt_tx;

  logic       clk;
  logic       reset_n;
  logic       i_evt;
  logic       i_ack;
  logic       i_overflow_clr;
  logic       o_req;
  logic [7:0] o_data;
  logic       o_busy;
  logic       o_overflow;
  logic       o_proto_err;

  int vec;
  int miss;
  int delivered;

  nvme_cdc_evt_tx #(
    .STAGES(3),
    .CW(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_evt(i_evt),
    .i_ack(i_ack),
    .i_overflow_clr(i_overflow_clr),
    .o_req(o_req),
    .o_data(o_data),
    .o_busy(o_busy),
    .o_overflow(o_overflow),
    .o_proto_err(o_proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 12) begin
      tick();
      n++;
    end
    chk(tag, o_busy, 0);
  endtask

  // Destination: echo req as ack five clocks later
  task automatic dest_ack(input string tag);
    repeat (5) tick();
    i_ack = o_req;
    wait_idle(tag);
  endtask

  initial begin
    vec = 0;
    miss = 0;
    delivered = 0;
    reset_n = 1'b0;
    i_evt = 1'b0;
    i_ack = 1'b0;
    i_overflow_clr = 1'b0;
    repeat (2) tick();
    chk("rst_req", o_req, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_perr", o_proto_err, 0);
    reset_n = 1'b1;
    tick();

    // 1: single event, exact launch and ack latency
    i_evt = 1'b1;
    tick();
    i_evt = 1'b0;
    chk("t1_req_e1", o_req, 0);
    tick();
    chk("t1_req_e2", o_req, 1);
    chk("t1_data", o_data, 1);
    chk("t1_busy", o_busy, 1);
    repeat (5) tick();
    i_ack = 1'b1;
    tick();
    chk("t1_busy_k", o_busy, 1);
    repeat (2) tick();
    chk("t1_busy_k2", o_busy, 1);
    tick();
    chk("t1_busy_k3", o_busy, 0);
    repeat (4) tick();
    chk("t1_no_req", o_req, 1);
    chk("t1_idle", o_busy, 0);
    chk("t1_perr", o_proto_err, 0);

    // 2: five events during WAIT
    i_evt = 1'b1;
    tick();
    i_evt = 1'b0;
    tick();
    chk("t2_prime_req", o_req, 0);
    chk("t2_prime_data", o_data, 1);
    for (int i = 0; i < 5; i++) begin
      i_evt = 1'b1;
      tick();
      i_evt = 1'b0;
    end
    dest_ack("t2_ack1");
    tick();
    chk("t2_data", o_data, 5);
    chk("t2_req", o_req, 1);
    chk("t2_busy", o_busy, 1);
    chk("t2_ovf", o_overflow, 0);
    dest_ack("t2_ack2");

    // 3: saturation, overflow, clear, set-wins
    i_evt = 1'b1;
    repeat (300) tick();
    i_evt = 1'b0;
    chk("t3_ovf", o_overflow, 1);
    chk("t3_hold_data", o_data, 1);
    chk("t3_hold_req", o_req, 0);
    dest_ack("t3_ack1");
    tick();
    chk("t3_data", o_data, 255);
    chk("t3_req", o_req, 1);
    i_overflow_clr = 1'b1;
    tick();
    i_overflow_clr = 1'b0;
    chk("t3_clr", o_overflow, 0);
    i_evt = 1'b1;
    repeat (255) tick();
    chk("t3_sat_no_ovf", o_overflow, 0);
    i_overflow_clr = 1'b1;
    tick();
    chk("t3_set_wins", o_overflow, 1);
    i_evt = 1'b0;
    tick();
    i_overflow_clr = 1'b0;
    chk("t3_clr2", o_overflow, 0);
    dest_ack("t3_ack2");
    tick();
    chk("t3_data2", o_data, 255);
    chk("t3_req2", o_req, 0);
    dest_ack("t3_ack3");

    // 4: event on the launch edge is carried by the next launch
    i_evt = 1'b1;
    tick();
    tick();
    i_evt = 1'b0;
    chk("t4_data1", o_data, 1);
    chk("t4_req1", o_req, 1);
    delivered = delivered + int'(o_data);
    dest_ack("t4_ack1");
    tick();
    chk("t4_data2", o_data, 1);
    chk("t4_req2", o_req, 0);
    delivered = delivered + int'(o_data);
    chk("t4_total", delivered, 2);
    dest_ack("t4_ack2");

    // 5: reset while waiting with a pending count
    i_evt = 1'b1;
    tick();
    i_evt = 1'b0;
    tick();
    chk("t5_launch", o_req, 1);
    i_evt = 1'b1;
    repeat (7) tick();
    i_evt = 1'b0;
    chk("t5_busy_pre", o_busy, 1);
    reset_n = 1'b0;
    i_ack = 1'b0;
    #1;
    chk("t5_req", o_req, 0);
    chk("t5_busy", o_busy, 0);
    chk("t5_data", o_data, 0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("t5_no_req", o_req, 0);
    chk("t5_no_busy", o_busy, 0);
    i_evt = 1'b1;
    tick();
    i_evt = 1'b0;
    tick();
    chk("t5_new_req", o_req, 1);
    chk("t5_new_data", o_data, 1);
    dest_ack("t5_ack");

    // 6: stray ack toggle while idle
    i_ack = 1'b0;
    tick();
    repeat (2) tick();
    chk("t6_perr_k2", o_proto_err, 0);
    tick();
    chk("t6_perr_k3", o_proto_err, 1);
    repeat (3) tick();
    chk("t6_sticky", o_proto_err, 1);
    chk("t6_busy", o_busy, 0);
    i_evt = 1'b1;
    tick();
    i_evt = 1'b0;
    tick();
    chk("t6_req", o_req, 0);
    chk("t6_data", o_data, 1);
    repeat (2) tick();
    chk("t6_sticky2", o_proto_err, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_clear", o_proto_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
